// File: rtl/wb_pkg.sv
// Shared types and constants for the NPC writeback stage.
//   wb_state_e : writeback FSM states
//   load_op_e  : load funct3 encodings
//   LANE_*     : byte/half/word lane widths used for extension
//   RegWidth / RegIdWidth : default data and register-index widths

// Fallback widths for builds that do not pull in the shared defines header first.
`ifndef REG_WIDTH
`define REG_WIDTH 64
`endif
`ifndef REG_ID_WIDTH
`define REG_ID_WIDTH 5
`endif

package wb_pkg;

  localparam int unsigned RegWidth   = `REG_WIDTH;
  localparam int unsigned RegIdWidth = `REG_ID_WIDTH;

  localparam int unsigned LANE_B = 8;
  localparam int unsigned LANE_H = 16;
  localparam int unsigned LANE_W = 32;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_LOAD
  } wb_state_e;

  typedef enum logic [2:0] {
    LOAD_B  = 3'b000,
    LOAD_H  = 3'b001,
    LOAD_W  = 3'b010,
    LOAD_D  = 3'b011,
    LOAD_BU = 3'b100,
    LOAD_HU = 3'b101,
    LOAD_WU = 3'b110
  } load_op_e;

  // A load is misaligned when the access does not fit its natural alignment.
  function automatic logic load_misaligned(logic [2:0] funct3, logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      LOAD_H, LOAD_HU: mis = addr_lo[0];
      LOAD_W, LOAD_WU: mis = |addr_lo[1:0];
      LOAD_D:          mis = |addr_lo;
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data aligner/extender.
//   rdata    : aligned memory doubleword
//   funct3   : load type
//   addr_lo  : load address bits [2:0]
//   wdata    : shifted lane, sign/zero extended per funct3
//   misalign : access is not naturally aligned

module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegWidth
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            funct3,
  input  logic [2:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misalign
);

  logic [DATA_WIDTH-1:0] lane;

  // Misaligned lanes simply shift in zeros from above bit 63.
  assign lane     = rdata >> {addr_lo, 3'b000};
  assign misalign = load_misaligned(funct3, addr_lo);

  always_comb begin
    wdata = '0;
    case (funct3)
      LOAD_B:  wdata = {{(DATA_WIDTH-LANE_B){lane[LANE_B-1]}}, lane[LANE_B-1:0]};
      LOAD_H:  wdata = {{(DATA_WIDTH-LANE_H){lane[LANE_H-1]}}, lane[LANE_H-1:0]};
      LOAD_W:  wdata = {{(DATA_WIDTH-LANE_W){lane[LANE_W-1]}}, lane[LANE_W-1:0]};
      LOAD_D:  wdata = lane;
      LOAD_BU: wdata = {{(DATA_WIDTH-LANE_B){1'b0}}, lane[LANE_B-1:0]};
      LOAD_HU: wdata = {{(DATA_WIDTH-LANE_H){1'b0}}, lane[LANE_H-1:0]};
      LOAD_WU: wdata = {{(DATA_WIDTH-LANE_W){1'b0}}, lane[LANE_W-1:0]};
      default: wdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction at a time into the register file.
//   in_*        : instruction from MEM stage (valid/ready handshake)
//   rdata_valid : one-cycle load data pulse, rdata carries the doubleword
//   reg_wen/rd/reg_wdata : register-file write port (registered)
//   commit      : one-cycle pulse per retired instruction
//   busy        : waiting for load data
//   misalign    : sticky misaligned-load flag, cleared only by rst

module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RegWidth,
  parameter int unsigned ADDR_WIDTH = RegIdWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  rdata_valid,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  reg_wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  commit,
  output logic                  busy,
  output logic                  misalign
);

  wb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_wen_q, ld_wen_d;
  logic [2:0]            ld_funct3_q, ld_funct3_d;
  logic [2:0]            ld_addr_lo_q, ld_addr_lo_d;

  logic                  reg_wen_q, reg_wen_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  commit_q, commit_d;
  logic                  misalign_q, misalign_d;

  logic                  accept;
  logic [2:0]            ext_funct3;
  logic [2:0]            ext_addr_lo;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic                  ext_misalign;

  assign accept = in_valid && (state_q == IDLE);

  // In IDLE the extender checks the incoming load for misalignment; in WAIT_LOAD
  // it formats the returning data using the latched load attributes.
  assign ext_funct3  = (state_q == IDLE) ? in_funct3  : ld_funct3_q;
  assign ext_addr_lo = (state_q == IDLE) ? in_addr_lo : ld_addr_lo_q;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .rdata   (rdata),
    .funct3  (ext_funct3),
    .addr_lo (ext_addr_lo),
    .wdata   (ext_wdata),
    .misalign(ext_misalign)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept && in_is_load) state_d = WAIT_LOAD;
      WAIT_LOAD: if (rdata_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath next-state: write port, commit, load context, sticky flag.
  always_comb begin
    ld_rd_d      = ld_rd_q;
    ld_wen_d     = ld_wen_q;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
    reg_wen_d    = 1'b0;
    commit_d     = 1'b0;
    rd_d         = rd_q;
    reg_wdata_d  = reg_wdata_q;
    misalign_d   = misalign_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_load) begin
            ld_rd_d      = in_rd;
            ld_wen_d     = in_wen;
            ld_funct3_d  = in_funct3;
            ld_addr_lo_d = in_addr_lo;
            if (ext_misalign) misalign_d = 1'b1;
          end else begin
            reg_wen_d   = in_wen && (in_rd != '0);
            rd_d        = in_rd;
            reg_wdata_d = in_result;
            commit_d    = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (rdata_valid) begin
          reg_wen_d   = ld_wen_q && (ld_rd_q != '0);
          rd_d        = ld_rd_q;
          reg_wdata_d = ext_wdata;
          commit_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output logic (all outputs come straight from flops).
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == WAIT_LOAD);
    reg_wen   = reg_wen_q;
    rd        = rd_q;
    reg_wdata = reg_wdata_q;
    commit    = commit_q;
    misalign  = misalign_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
      reg_wen_q    <= 1'b0;
      rd_q         <= '0;
      reg_wdata_q  <= '0;
      commit_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_rd_q      <= ld_rd_d;
      ld_wen_q     <= ld_wen_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      reg_wen_q    <= reg_wen_d;
      rd_q         <= rd_d;
      reg_wdata_q  <= reg_wdata_d;
      commit_q     <= commit_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule
